// File: rtl/fwd_forwarding_unit_pkg.sv
// Shared definitions for the operand forwarding unit: default register-address
// width, the x0 address and the forwarding-select encodings.
package fwd_forwarding_unit_pkg;

    // Default register-address width (32-entry register file)
    localparam int unsigned FWD_REG_ADDR_W_DEF = 5;

    // Register x0 is hard-wired to zero and is never a forwarding source
    localparam int unsigned FWD_X0_ADDR = 0;

    // Forwarding select: bit0 = operand A, bit1 = operand B
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_A    = 2'b01;
    localparam fwd_sel_t FWD_B    = 2'b10;
    localparam fwd_sel_t FWD_AB   = 2'b11;

    // Map per-operand hit flags onto the select encoding
    function automatic fwd_sel_t fwd_sel_pack(input logic a_hit, input logic b_hit);
        case ({b_hit, a_hit})
            2'b01:   return FWD_A;
            2'b10:   return FWD_B;
            2'b11:   return FWD_AB;
            default: return FWD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fwd_forwarding_unit_match_cmp.sv
// Single-level forwarding comparator: flags which source operands of the
// decode-slot instruction match a producing destination register.
module fwd_match_cmp
    import fwd_forwarding_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = FWD_REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] ra_i,
    input  logic [REG_ADDR_W-1:0] rb_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output fwd_sel_t              sel_o
);

    logic rd_live;
    logic a_hit;
    logic b_hit;

    // Compare both sources against rd; a write to x0 never forwards
    always_comb begin
        rd_live = (rd_i != REG_ADDR_W'(FWD_X0_ADDR));
        a_hit   = rd_live && (ra_i == rd_i);
        b_hit   = rd_live && (rb_i == rd_i);
        sel_o   = fwd_sel_pack(a_hit, b_hit);
    end

endmodule

// File: rtl/fwd_forwarding_unit.sv
// Operand forwarding unit. The ID-stage select is purely combinational.
// Optional EX-stage tracking is enabled with macro FWD_EX_STAGE_EN, which adds
// an ex_rd register and the fwd_ex_sel_out port.
module fwd_forwarding_unit
    import fwd_forwarding_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = FWD_REG_ADDR_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [REG_ADDR_W-1:0] fwd_if_ra_addr_in,
    input  logic [REG_ADDR_W-1:0] fwd_if_rb_addr_in,
    input  logic [REG_ADDR_W-1:0] fwd_id_rd_addr_in,
    output logic [1:0]            fwd_mux_sel_out
`ifdef FWD_EX_STAGE_EN
   ,output logic [1:0]            fwd_ex_sel_out
`endif
);

    fwd_sel_t id_sel;

    fwd_match_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_id_cmp (
        .ra_i  (fwd_if_ra_addr_in),
        .rb_i  (fwd_if_rb_addr_in),
        .rd_i  (fwd_id_rd_addr_in),
        .sel_o (id_sel)
    );

    // ID-stage select drives the output directly, independent of clock/reset
    always_comb begin
        fwd_mux_sel_out = id_sel;
    end

`ifdef FWD_EX_STAGE_EN
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic [REG_ADDR_W-1:0] ex_rd_d;
    fwd_sel_t              ex_sel;

    // ex_rd follows the ID destination one cycle later
    always_comb begin
        ex_rd_d = fwd_id_rd_addr_in;
    end

    // ex_rd register; reset to x0 so nothing forwards from EX
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ex_rd_q <= '0;
        end else begin
            ex_rd_q <= ex_rd_d;
        end
    end

    fwd_match_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_ex_cmp (
        .ra_i  (fwd_if_ra_addr_in),
        .rb_i  (fwd_if_rb_addr_in),
        .rd_i  (ex_rd_q),
        .sel_o (ex_sel)
    );

    // Newer ID result wins: any operand hit by both levels suppresses EX
    always_comb begin
        if ((ex_sel & id_sel) != FWD_NONE) begin
            fwd_ex_sel_out = FWD_NONE;
        end else begin
            fwd_ex_sel_out = ex_sel;
        end
    end
`else
    logic unused_clk_rst;

    // Clock and reset exist only for port compatibility in this build
    always_comb begin
        unused_clk_rst = &{1'b0, clk_in, rst_n_in};
    end
`endif

endmodule

// File: tb/tb_fwd_forwarding_unit.sv
// Scoreboard bench for fwd_forwarding_unit: a driver applies directed and
// random address vectors and queues the expected selects from a reference
// model; a monitor pops and compares at each falling clock edge.
// Macro FWD_EX_STAGE_EN enables the EX-stage checks.
module tb_fwd_forwarding_unit;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rd;
    logic [1:0]    mux_sel;
    logic [1:0]    ex_sel;

    typedef struct {
        int         idx;
        logic [1:0] mux;
        logic [1:0] ex;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   vec_idx  = 0;
    int   model_ex_rd = 0;

    fwd_forwarding_unit #(
        .REG_ADDR_W (AW)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .fwd_if_ra_addr_in (ra),
        .fwd_if_rb_addr_in (rb),
        .fwd_id_rd_addr_in (rd),
        .fwd_mux_sel_out   (mux_sel)
`ifdef FWD_EX_STAGE_EN
       ,.fwd_ex_sel_out    (ex_sel)
`endif
    );

`ifndef FWD_EX_STAGE_EN
    assign ex_sel = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a source forwards when it names the producing register, unless that is x0
    function automatic int ref_sel(input int a, input int b, input int d);
        int r;
        r = 0;
        if (d != 0 && a == d) r = r + 1;
        if (d != 0 && b == d) r = r + 2;
        return r;
    endfunction

    function automatic int ref_ex(input int a, input int b, input int d_id, input int d_ex);
        int s_id;
        int s_ex;
        s_id = ref_sel(a, b, d_id);
        s_ex = ref_sel(a, b, d_ex);
        if ((s_id & s_ex) != 0) return 0;
        return s_ex;
    endfunction

    task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s vec=%0d ra=%0d rb=%0d rd=%0d got=%b expected=%b",
                     name, idx, ra, rb, rd, act, req);
        end
    endtask

    // Apply one vector just after a rising edge and queue its expected response
    task automatic apply(input int a, input int b, input int d, input logic rn);
        exp_t e;
        @(posedge clk);
        if (rst_n === 1'b1) model_ex_rd = int'(rd);
        else                model_ex_rd = 0;
        #2;
        ra    = AW'(a);
        rb    = AW'(b);
        rd    = AW'(d);
        rst_n = rn;
        if (!rn) model_ex_rd = 0;
        e.idx = vec_idx;
        e.mux = 2'(ref_sel(a % 32, b % 32, d % 32));
        e.ex  = 2'(ref_ex(a % 32, b % 32, d % 32, model_ex_rd));
        sb_q.push_back(e);
        n_pushed++;
        vec_idx++;
    endtask

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_popped++;
                check("mux_sel", e.idx, mux_sel, e.mux);
`ifdef FWD_EX_STAGE_EN
                check("ex_sel", e.idx, ex_sel, e.ex);
`endif
            end
        end
    end

    // Driver
    initial begin
        int a;
        int b;
        int d;
        int k;
        rst_n = 1'b0;
        ra    = '0;
        rb    = '0;
        rd    = '0;

        // Reset state, with combinational path live during reset
        apply(5, 7, 5, 1'b0);
        apply(0, 0, 0, 1'b0);
        apply(0, 0, 0, 1'b1);

        // Directed patterns
        apply(5, 7, 5, 1'b1);
        apply(3, 9, 9, 1'b1);
        apply(12, 12, 12, 1'b1);
        apply(0, 0, 0, 1'b1);
        apply(4, 6, 8, 1'b1);
        apply(0, 3, 0, 1'b1);
        apply(31, 31, 31, 1'b1);
        apply(31, 30, 30, 1'b1);

        // EX-level hit, then ID priority over EX
        apply(1, 1, 10, 1'b1);
        apply(10, 2, 11, 1'b1);
        apply(0, 0, 10, 1'b1);
        apply(10, 3, 10, 1'b1);
        apply(4, 4, 4, 1'b1);
        apply(4, 4, 6, 1'b1);

        // Mid-sequence reset pulse
        apply(0, 0, 9, 1'b1);
        apply(9, 9, 9, 1'b0);
        apply(9, 2, 2, 1'b0);
        apply(9, 2, 0, 1'b1);
        apply(9, 2, 5, 1'b1);
        apply(5, 9, 7, 1'b1);

        // Random vectors, narrow address range so matches are frequent
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0) begin
                a = $urandom_range(0, 31);
                b = $urandom_range(0, 31);
                d = $urandom_range(0, 31);
            end else begin
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 3);
                d = $urandom_range(0, 3);
            end
            apply(a, b, d, ($urandom_range(0, 19) != 0));
        end

        // Drain scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (n_popped == n_pushed && sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain popped=%0d expected=%0d", n_popped, n_pushed);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
